// File: rtl/fp32_div_pkg.sv
// Shared constants and types for the FP32 divider arbiter slice.
package fp32_div_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int NUM_REQ_DEFAULT = 4;
    localparam int ID_W_DEFAULT    = $clog2(NUM_REQ_DEFAULT);

    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef logic [ID_W_DEFAULT-1:0] req_id_t;

endpackage

// File: rtl/div_v2.sv
// Combinational IEEE-754 single-precision divider, round-to-nearest-even.
// Subnormal inputs are read as zero and results below the normal range flush to zero.
module div_v2
    import fp32_div_pkg::*;
(
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out
);

    logic               w_sign;
    logic [7:0]         w_ea, w_eb;
    logic [22:0]        w_fa, w_fb;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [24:0]        w_rem;
    logic [26:0]        w_q;
    logic [22:0]        w_frac;
    logic               w_guard, w_sticky, w_rnd;
    logic signed [10:0] w_exp;

    // Special-case decode, 27-bit restoring mantissa division, normalise and round
    always_comb begin
        w_sign   = in1[31] ^ in2[31];
        w_ea     = in1[30:23];
        w_eb     = in2[30:23];
        w_fa     = in1[22:0];
        w_fb     = in2[22:0];
        w_a_zero = (w_ea == 8'd0);
        w_b_zero = (w_eb == 8'd0);
        w_a_inf  = (w_ea == 8'hFF) && (w_fa == '0);
        w_b_inf  = (w_eb == 8'hFF) && (w_fb == '0);
        w_a_nan  = (w_ea == 8'hFF) && (w_fa != '0);
        w_b_nan  = (w_eb == 8'hFF) && (w_fb != '0);
        w_rem    = '0;
        w_q      = '0;
        w_frac   = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_rnd    = 1'b0;
        w_exp    = '0;
        out      = FP32_ZERO;

        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            out = FP32_QNAN;
        end else if (w_a_inf || w_b_zero) begin
            out = {w_sign, FP32_PINF[30:0]};
        end else if (w_a_zero || w_b_inf) begin
            out = {w_sign, FP32_ZERO[30:0]};
        end else begin
            // Quotient q = floor(ma * 2^26 / mb), ma/mb in (0.5, 2)
            w_rem = {2'b01, w_fa};
            for (int unsigned i = 0; i < 27; i++) begin
                if (i != 0) begin
                    w_rem = {w_rem[23:0], 1'b0};
                end
                w_q = {w_q[25:0], (w_rem >= {2'b01, w_fb})};
                if (w_q[0]) begin
                    w_rem = w_rem - {2'b01, w_fb};
                end
            end
            if (w_q[26]) begin
                w_frac   = w_q[25:3];
                w_guard  = w_q[2];
                w_sticky = (|w_q[1:0]) || (w_rem != '0);
                w_exp    = $signed({3'b000, w_ea}) - $signed({3'b000, w_eb}) + 11'sd127;
            end else begin
                w_frac   = w_q[24:2];
                w_guard  = w_q[1];
                w_sticky = w_q[0] || (w_rem != '0);
                w_exp    = $signed({3'b000, w_ea}) - $signed({3'b000, w_eb}) + 11'sd126;
            end
            w_rnd = w_guard && (w_sticky || w_frac[0]);
            if (w_exp >= 11'sd255) begin
                out = {w_sign, FP32_PINF[30:0]};
            end else if (w_exp <= 11'sd0) begin
                out = {w_sign, FP32_ZERO[30:0]};
            end else begin
                // A rounding carry out of the fraction bumps the exponent, up to +inf
                out = {w_sign, {w_exp[7:0], w_frac} + {30'd0, w_rnd}};
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned N = NUM_REQ;

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    // One-hot grant to the first requester after ptr
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = ID_W'((32'(ptr) + k) % N);
            if (en && !w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp32_div_arbiter.sv
// Round-robin sharing of one FP32 divider core among NUM_REQ requesters,
// with an operand stage (S1) and a result stage (S2) that advance together.
module fp32_div_arbiter
    import fp32_div_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH = fp32_div_pkg::DATA_WIDTH,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]               resp_id,
    output logic [1:0]                    busy_cnt
);

    logic                  r_s1_valid, r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s1_a, r_s1_b, r_s2_data;
    logic [ID_W-1:0]       r_s1_id, r_s2_id, r_ptr;

    logic                  w_advance;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_gidx;
    logic [DATA_WIDTH-1:0] w_mux_a, w_mux_b, w_core_out;

    assign w_advance  = !r_s2_valid || resp_ready;
    assign req_ready  = w_grant & {NUM_REQ{w_advance}};
    assign resp_valid = r_s2_valid;
    assign resp_data  = r_s2_data;
    assign resp_id    = r_s2_id;
    assign busy_cnt   = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (!rst),
        .grant (w_grant)
    );

    // Granted index and its operands
    always_comb begin
        w_gidx  = '0;
        w_mux_a = '0;
        w_mux_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx  = ID_W'(i);
                w_mux_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_mux_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    div_v2 u_core (
        .in1 (r_s1_a),
        .in2 (r_s1_b),
        .out (w_core_out)
    );

    // Pipeline stages and arbitration pointer; everything moves only on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= FP32_ZERO;
            r_s1_b     <= FP32_ZERO;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= FP32_ZERO;
            r_s2_id    <= '0;
            r_ptr      <= ID_W'(NUM_REQ - 1);
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_core_out;
                r_s2_id   <= r_s1_id;
            end
            r_s1_valid <= |w_grant;
            if (|w_grant) begin
                r_s1_a  <= w_mux_a;
                r_s1_b  <= w_mux_b;
                r_s1_id <= w_gidx;
                r_ptr   <= w_gidx;
            end
        end
    end

endmodule
